blink_rate_decoder: RTL and testbench

- Receive end of the LED blink scheme: watches a slow square wave on an input pin and recovers which of the four blink rates drives it (0.5 s / 1 s / 2 s / 3 s half-period).
- Reports the rate one-hot on LEDs together with valid, error and stall flags.
- Sits between a board input (GPIO or a looped-back LED line) and the LEDR/LEDG drivers.
- Runs on the 50 MHz board clock.

---
 rtl/blink_rate_decoder.sv | 182 ++++++++++++++++++
 tb/tb_blink_rate_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_rate_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : blink_rate_decoder
//  Description : Recovers which of four blink rates drives a slow square wave
//                on an input pin. Measures edge-to-edge spacing, classifies it
//                against four nominal half-periods with a tolerance window and
//                reports the confirmed rate one-hot with valid/error/stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module blink_rate_decoder #(
    parameter int unsigned HP0         = 25000000,
    parameter int unsigned HP1         = 50000000,
    parameter int unsigned HP2         = 100000000,
    parameter int unsigned HP3         = 150000000,
    parameter int unsigned TOL         = 2500000,
    parameter int unsigned TIMEOUT_CYC = 200000000,
    parameter int          CNT_W       = 28
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             BLINK_IN,
    output logic [3:0]       RATE,
    output logic             VALID,
    output logic             ERR,
    output logic             STALL,
    output logic [CNT_W-1:0] HALF_PERIOD
);

    // Two-state measurement controller: FIRST waits for a reference edge,
    // RUN measures and classifies every following edge-to-edge spacing.
    localparam logic [0:0] c_ST_FIRST = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    // Synchronizer (r_sync1/r_sync2) plus a delayed copy for edge detection.
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic             w_det;

    logic [CNT_W-1:0] r_cnt;

    logic [0:0]       r_state;
    logic             r_cand_vld;
    logic [1:0]       r_cand;
    logic [1:0]       r_conf;
    logic [1:0]       w_conf_next;
    logic [3:0]       r_rate;
    logic             r_valid;
    logic             r_err;
    logic             r_stall;
    logic [CNT_W-1:0] r_half;

    logic [3:0]       w_match;
    logic             w_match_any;
    logic [1:0]       w_match_idx;
    logic             w_same_cand;

    // Both polarities of transition count as an edge.
    assign w_det = r_sync2 ^ r_sync3;

    // Bring the asynchronous pin into the clock domain and keep one more stage for edge detect.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= BLINK_IN;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Spacing counter: restarts at 1 on every edge so it holds the exact spacing at the next edge.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (w_det) begin
            r_cnt <= c_ONE;
        end else if (r_cnt < c_TIMEOUT) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    // One tolerance window per rate; windows never overlap, so at most one bit is set.
    for (genvar k = 0; k < 4; k++) begin : g_rate
        localparam int unsigned c_HPK = (k == 0) ? HP0 :
                                        (k == 1) ? HP1 :
                                        (k == 2) ? HP2 : HP3;
        localparam logic [CNT_W-1:0] c_LO = CNT_W'(c_HPK - TOL);
        localparam logic [CNT_W-1:0] c_HI = CNT_W'(c_HPK + TOL);
        assign w_match[k] = (r_cnt >= c_LO) && (r_cnt <= c_HI);
    end

    // Encode the matching rate index and compare it with the current candidate.
    always_comb begin
        w_match_any = |w_match;
        w_match_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (w_match[k]) begin
                w_match_idx = 2'(k);
            end
        end
        w_same_cand = r_cand_vld && (r_cand == w_match_idx);
        w_conf_next = (r_conf == 2'd2) ? 2'd2 : r_conf + 2'd1;
    end

    // Measurement controller with registered outputs; detection takes priority over timeout.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state    <= c_ST_FIRST;
            r_cand_vld <= 1'b0;
            r_cand     <= 2'd0;
            r_conf     <= 2'd0;
            r_rate     <= 4'd0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_stall    <= 1'b0;
            r_half     <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                c_ST_FIRST: begin
                    // The first edge is only a reference; nothing to classify yet.
                    if (w_det) begin
                        r_stall <= 1'b0;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (w_det) begin
                        r_half <= r_cnt;
                        if (w_match_any && w_same_cand) begin
                            r_conf <= w_conf_next;
                            if (w_conf_next == 2'd2) begin
                                r_valid <= 1'b1;
                                r_rate  <= w_match;
                            end
                        end else if (w_match_any) begin
                            r_cand_vld <= 1'b1;
                            r_cand     <= w_match_idx;
                            r_conf     <= 2'd1;
                            r_valid    <= 1'b0;
                            r_rate     <= 4'd0;
                        end else begin
                            // Bad spacing: drop the lock but keep this edge as the next reference.
                            r_err      <= 1'b1;
                            r_valid    <= 1'b0;
                            r_rate     <= 4'd0;
                            r_cand_vld <= 1'b0;
                            r_cand     <= 2'd0;
                            r_conf     <= 2'd0;
                        end
                    end else if (r_cnt == c_TIMEOUT) begin
                        r_stall    <= 1'b1;
                        r_valid    <= 1'b0;
                        r_rate     <= 4'd0;
                        r_cand_vld <= 1'b0;
                        r_cand     <= 2'd0;
                        r_conf     <= 2'd0;
                        r_state    <= c_ST_FIRST;
                    end
                end
                default: begin
                    r_state <= c_ST_FIRST;
                end
            endcase
        end
    end

    assign RATE        = r_rate;
    assign VALID       = r_valid;
    assign ERR         = r_err;
    assign STALL       = r_stall;
    assign HALF_PERIOD = r_half;

endmodule
`default_nettype wire

// File: tb/tb_blink_rate_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_blink_rate_decoder
//  Description : Self-checking bench for blink_rate_decoder. Directed steps
//                followed by random spacings, all checked against a
//                behavioural model built on a history of classified spacings.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_blink_rate_decoder;

    localparam int HP0         = 25;
    localparam int HP1         = 50;
    localparam int HP2         = 100;
    localparam int HP3         = 150;
    localparam int TOL         = 3;
    localparam int TIMEOUT_CYC = 200;
    localparam int CNT_W       = 8;
    // Pin-to-output latency: two synchronizer stages plus the registered decision.
    localparam int LAT         = 3;

    logic             CLOCK_50 = 1'b0;
    logic             RESET;
    logic             BLINK_IN;
    logic [3:0]       RATE;
    logic             VALID;
    logic             ERR;
    logic             STALL;
    logic [CNT_W-1:0] HALF_PERIOD;

    blink_rate_decoder #(
        .HP0(HP0), .HP1(HP1), .HP2(HP2), .HP3(HP3),
        .TOL(TOL), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .BLINK_IN   (BLINK_IN),
        .RATE       (RATE),
        .VALID      (VALID),
        .ERR        (ERR),
        .STALL      (STALL),
        .HALF_PERIOD(HALF_PERIOD)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_assert = 0;
    int n_fail   = 0;
    int since    = 0;   // cycles since the last pin toggle (or reset release)

    // Reference model: whether a reference edge exists, and the list of
    // rate classes seen since the last break (reset, stall or bad spacing).
    int       hp_tab [4] = '{HP0, HP1, HP2, HP3};
    int       m_q [$];
    bit       m_run;
    bit       m_stall;
    bit       m_err;
    bit       m_valid;
    logic [3:0] m_rate;
    int       m_hp;

    function automatic int classify(input int d);
        for (int k = 0; k < 4; k++) begin
            if (d >= hp_tab[k] - TOL && d <= hp_tab[k] + TOL) return k;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_run = 0; m_stall = 0; m_err = 0; m_valid = 0; m_rate = 4'd0; m_hp = 0;
    endfunction

    function automatic void model_stall();
        m_stall = 1; m_run = 0; m_valid = 0; m_rate = 4'd0;
        m_q.delete();
    endfunction

    function automatic void model_edge(input int d);
        int k;
        m_err = 0;
        if (m_run && d > TIMEOUT_CYC) model_stall();
        if (!m_run) begin
            m_run   = 1;
            m_stall = 0;
        end else begin
            m_hp = d;
            k = classify(d);
            if (k < 0) begin
                m_err = 1; m_valid = 0; m_rate = 4'd0;
                m_q.delete();
            end else begin
                m_q.push_back(k);
                if (m_q.size() >= 2 && m_q[m_q.size()-1] == m_q[m_q.size()-2]) begin
                    m_valid = 1;
                    m_rate  = 4'(1 << k);
                end else begin
                    m_valid = 0;
                    m_rate  = 4'd0;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".RATE"},        32'(RATE),        32'(m_rate));
        chk({tag, ".VALID"},       32'(VALID),       32'(m_valid));
        chk({tag, ".ERR"},         32'(ERR),         32'(m_err));
        chk({tag, ".STALL"},       32'(STALL),       32'(m_stall));
        chk({tag, ".HALF_PERIOD"}, 32'(HALF_PERIOD), 32'(m_hp));
    endtask

    // Advance n cycles; outputs are sampled 1 ns after the rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
            since++;
            if (m_run && since == TIMEOUT_CYC + LAT) model_stall();
        end
    endtask

    // Toggle the pin d cycles after the previous toggle, then check the decision and the ERR pulse width.
    task automatic edge_at(input int d, input string tag);
        int actual;
        if (since < d) cyc(d - since);
        actual = since;
        BLINK_IN = ~BLINK_IN;
        since = 0;
        model_edge(actual);
        cyc(LAT);
        check_all(tag);
        cyc(1);
        m_err = 0;
        chk({tag, ".err_one_cycle"}, 32'(ERR), 32'(0));
    endtask

    // A normal edge followed one cycle later by a second edge.
    task automatic glitch(input int d1, input string tag);
        if (since < d1) cyc(d1 - since);
        BLINK_IN = ~BLINK_IN;
        model_edge(since);
        since = 0;
        cyc(1);
        BLINK_IN = ~BLINK_IN;
        model_edge(since);
        since = 0;
        cyc(LAT);
        check_all(tag);
        cyc(1);
        m_err = 0;
        chk({tag, ".err_one_cycle"}, 32'(ERR), 32'(0));
    endtask

    // One-cycle reset; the pin is low here so no edge appears when the synchronizer clears.
    task automatic pulse_reset(input string tag);
        RESET = 1'b1;
        @(posedge CLOCK_50);
        #1;
        RESET = 1'b0;
        model_reset();
        since = 0;
        check_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        int k;
        BLINK_IN = 1'b0;
        RESET    = 1'b1;
        model_reset();
        repeat (3) @(posedge CLOCK_50);
        #1;
        RESET = 1'b0;
        since = 0;
        check_all("reset");

        // Steady input: no edge ever seen, so no stall either.
        cyc(250);
        check_all("idle");

        // Lock onto the 1 s rate.
        edge_at(50, "r1_e1");
        edge_at(50, "r1_e2");
        edge_at(50, "r1_e3");
        edge_at(50, "r1_e4");

        // Rate changes: one spacing drops the lock, the next restores it.
        edge_at(100, "r2_e1");
        edge_at(100, "r2_e2");
        edge_at(150, "r3_e1");
        edge_at(150, "r3_e2");

        // Tolerance boundaries.
        edge_at(47, "tol_47");
        edge_at(53, "tol_53");
        edge_at(54, "tol_54");
        edge_at(50, "relock_a");
        edge_at(50, "relock_b");

        // Lock at 25 then let the input go quiet.
        edge_at(25, "r0_e1");
        edge_at(25, "r0_e2");
        edge_at(25, "r0_e3");
        cyc(TIMEOUT_CYC + LAT - 1 - since);
        chk("stall_not_early", 32'(STALL), 32'(0));
        cyc(1);
        check_all("stall");
        edge_at(240, "stall_clear");

        // Relock at 25, then a one-cycle glitch.
        edge_at(25, "g_e1");
        edge_at(25, "g_e2");
        chk("g_locked", 32'(VALID), 32'(m_valid));
        glitch(12, "glitch");

        // Relock, then reset in the middle of a measurement.
        edge_at(24, "rs_e1");
        edge_at(25, "rs_e2");
        edge_at(25, "rs_e3");
        if (BLINK_IN) edge_at(25, "rs_even");
        cyc(10);
        pulse_reset("mid_reset");
        edge_at(25, "post_rst_e1");
        edge_at(25, "post_rst_e2");
        edge_at(25, "post_rst_e3");

        // Random spacings: mostly near a nominal rate (sometimes just outside), some arbitrary.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                k = int'($urandom_range(0, 3));
                d = hp_tab[k] + int'($urandom_range(0, 2*TOL + 2)) - (TOL + 1);
            end else begin
                d = int'($urandom_range(4, 215));
            end
            if ($urandom_range(0, 19) == 0 && BLINK_IN == 1'b0) pulse_reset("rand_reset");
            edge_at(d, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
